mips_state_ctrl: RTL

MIPS_STATE_CTRL -- requirements
Module: mips_state_ctrl

---
 rtl/mips_state_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/mips_state_ctrl.sv
// rtl/mips_state_ctrl.sv - multi-cycle MIPS control state machine (fetch/decode/exec/mem/writeback)
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset        asynchronous active-low reset; holds State=FETCH, all enables 0
//   Instruction  current instruction word (stable from DECODE through WB)
//   RegPC        current PC; a zero PC in FETCH halts the CPU
//   waitrequest  memory stall, holds FETCH/MEM while high
//   alu_busy     multiply/divide still computing, holds EXEC while high
//   State        current state code fed to the PC block (PC updates only in WB)
//   mem_read     memory read request (instruction fetch or load)
//   mem_write    memory write request (store)
//   addr_sel     memory address source: 0 = RegPC, 1 = ALU result
//   ir_write     instruction register load, pulses when FETCH completes
//   reg_write    register file write enable, WB only
//   active       CPU running; 0 once halted
module mips_state_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instruction,
    input  logic [31:0] RegPC,
    input  logic        waitrequest,
    input  logic        alu_busy,
    output logic [2:0]  State,
    output logic        mem_read,
    output logic        mem_write,
    output logic        addr_sel,
    output logic        ir_write,
    output logic        reg_write,
    output logic        active
);

    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    state_t state_q;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       is_load;
    logic       is_store;
    logic       writes_reg;
    logic       pc_zero;

    // rs, rd and shamt do not influence control flow here
    logic unused_fields;
    assign unused_fields = ^{Instruction[25:21], Instruction[15:6]};

    assign opcode  = Instruction[31:26];
    assign funct   = Instruction[5:0];
    assign rt      = Instruction[20:16];
    assign pc_zero = (RegPC == 32'd0);

    always_comb begin
        is_load = (opcode >= 6'h20) && (opcode <= 6'h26);
        is_store = (opcode == 6'h28) || (opcode == 6'h29) || (opcode == 6'h2B);

        writes_reg = 1'b0;
        if (opcode == 6'h00) begin
            // R-type writes rd except jumps to register and HI/LO-only ops
            case (funct)
                6'h08, 6'h11, 6'h13,
                6'h18, 6'h19, 6'h1A, 6'h1B: writes_reg = 1'b0;
                default:                    writes_reg = 1'b1;
            endcase
        end else if (opcode >= 6'h08 && opcode <= 6'h0F) begin
            writes_reg = 1'b1;
        end else if (is_load) begin
            writes_reg = 1'b1;
        end else if (opcode == 6'h03) begin
            writes_reg = 1'b1;
        end else if (opcode == 6'h01 && (rt == 5'h10 || rt == 5'h11)) begin
            writes_reg = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (pc_zero)
                        state_q <= S_HALT;
                    else if (!waitrequest)
                        state_q <= S_DECODE;
                end
                S_DECODE: state_q <= S_EXEC;
                S_EXEC: begin
                    if (!alu_busy)
                        state_q <= (is_load || is_store) ? S_MEM : S_WB;
                end
                S_MEM: begin
                    if (!waitrequest)
                        state_q <= S_WB;
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                // unused codes 6/7 park in HALT so no enable can ever fire
                default: state_q <= S_HALT;
            endcase
        end
    end

    // Enables are decoded from the registered state plus the same-cycle
    // stall inputs: ir_write must coincide with the accepted fetch, and the
    // fetch request depends on the PC presented in that cycle. Every enable
    // is qualified by reset so assertion kills it without waiting for clk.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = !pc_zero;
                    ir_write = !pc_zero && !waitrequest;
                end
                S_MEM: begin
                    addr_sel  = 1'b1;
                    mem_read  = is_load;
                    mem_write = !is_load && is_store;
                end
                S_WB:    reg_write = writes_reg;
                default: ;
            endcase
        end
    end

    assign State  = state_q;
    assign active = (state_q != S_HALT);

endmodule
